// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with CTRL / PRESET / COUNT
// registers, one-shot and auto-reload modes, and a maskable interrupt.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ctrl;
  logic [3:0]  w_ctrl_next;
  logic [31:0] r_preset;
  logic [31:0] w_preset_next;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_irq;
  logic        w_irq_next;

  logic [1:0]  w_sel;
  logic        w_enable;
  logic        w_autoreload;
  logic        w_unused_addr;

  // Only the word offset inside the window is decoded; the bridge does range select.
  assign w_sel         = addr[1:0];
  assign w_unused_addr = ^addr[29:2];
  assign w_enable      = r_ctrl[0];
  // Modes 2 and 3 fall back to one-shot, so only encoding 1 reloads.
  assign w_autoreload  = (r_ctrl[2:1] == 2'd1);

  // State and register update; reset outranks any simultaneous CPU write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ctrl   <= w_ctrl_next;
      r_preset <= w_preset_next;
      r_count  <= w_count_next;
      r_irq    <= w_irq_next;
    end
  end

  // Next-state and register next values; the CPU write is applied last so it
  // overrides the one-shot Enable clear taken in INT.
  always_comb begin
    w_state_next  = r_state;
    w_ctrl_next   = r_ctrl;
    w_preset_next = r_preset;
    w_count_next  = r_count;
    w_irq_next    = r_irq;

    case (r_state)
      S_IDLE: begin
        if (w_enable) begin
          w_state_next = S_LOAD;
          w_irq_next   = 1'b0;
        end
      end
      S_LOAD: begin
        w_count_next = r_preset;
        w_state_next = S_CNT;
      end
      S_CNT: begin
        if (!w_enable) begin
          w_state_next = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_next = r_count - 32'd1;
        end else begin
          w_count_next = 32'd0;
          w_irq_next   = 1'b1;
          w_state_next = S_INT;
        end
      end
      S_INT: begin
        if (w_autoreload) begin
          w_irq_next = 1'b0;
        end else begin
          // One-shot keeps the flag raised until software re-enables.
          w_ctrl_next[0] = 1'b0;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (we) begin
      case (w_sel)
        A_CTRL:   w_ctrl_next   = wdata[3:0];
        A_PRESET: w_preset_next = wdata;
        default:  ;
      endcase
    end
  end

  // Zero-latency read mux; unstored CTRL bits and word 3 read as zero.
  always_comb begin
    rdata = 32'd0;
    case (w_sel)
      A_CTRL:   rdata = {28'd0, r_ctrl};
      A_PRESET: rdata = r_preset;
      A_COUNT:  rdata = r_count;
      default:  rdata = 32'd0;
    endcase
  end

  assign irq = r_irq & r_ctrl[3];

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed scenarios with hand-computed values plus a long
// randomized run, all checked every cycle against a rule-level model.
module tb_timer_device;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  timer_device dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 reload pending, 2 counting, 3 expiry cycle
  int          m_phase = 0;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  bit          m_flag = 0;

  always @(posedge clk) begin
    logic [3:0]  nc;
    logic [31:0] np;
    logic [31:0] ncnt;
    bit          nf;
    int          nph;
    if (reset) begin
      m_phase = 0; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 0;
    end else begin
      nc = m_ctrl; np = m_preset; ncnt = m_count; nf = m_flag; nph = m_phase;
      if (m_phase == 0 && m_ctrl[0]) begin
        nph = 1; nf = 0;
      end else if (m_phase == 1) begin
        ncnt = m_preset; nph = 2;
      end else if (m_phase == 2) begin
        if (!m_ctrl[0]) nph = 0;
        else if (m_count >= 2) ncnt = m_count - 1;
        else begin ncnt = 0; nf = 1; nph = 3; end
      end else if (m_phase == 3) begin
        if (m_ctrl[2:1] == 2'b01) nf = 0;
        else nc = {m_ctrl[3:1], 1'b0};
        nph = 0;
      end
      if (we && addr[1:0] == 2'd0) nc = wdata[3:0];
      if (we && addr[1:0] == 2'd1) np = wdata;
      m_ctrl = nc; m_preset = np; m_count = ncnt; m_flag = nf; m_phase = nph;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    if (a == 2'd0) return {28'd0, m_ctrl};
    if (a == 2'd1) return m_preset;
    if (a == 2'd2) return m_count;
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata", rdata, model_read(addr[1:0]));
      check("model_irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    end
  end

  // One bus cycle: drive inputs, wait for the edge, settle.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d, input logic r);
    we = w; addr = {28'd0, a}; wdata = d; reset = r;
    @(posedge clk);
    #1;
    $display("cyc t=%0t rst=%0b we=%0b addr=%0d wdata=%h -> rdata=%h irq=%0b",
             $time, r, w, a, d, rdata, irq);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, a, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 32'd0, 1'b1);
  endtask

  initial begin
    logic        rw;
    logic        rr;
    logic [1:0]  ra;
    logic [31:0] rdat;

    we = 1'b0; addr = 30'd0; wdata = 32'd0; reset = 1'b1;
    do_reset();
    chk_en = 1;

    // Reset values
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0]);
      check("reset_read", rdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
    end

    // Mode 0 one-shot, PRESET=5
    do_reset();
    step(1'b1, 2'd1, 32'd5, 1'b0);
    step(1'b1, 2'd0, 32'h9, 1'b0);       // E0
    rd(2'd2);                             // E1
    for (int k = 2; k <= 6; k++) begin
      rd(2'd2);
      check("m0_count", rdata, 32'(7 - k));
    end
    rd(2'd2);                             // E7
    check("m0_count_zero", rdata, 32'd0);
    check("m0_irq_rise", {31'd0, irq}, 32'd1);
    rd(2'd0);                             // E8
    check("m0_ctrl_cleared", rdata, 32'h8);
    rd(2'd0);
    check("m0_irq_hold", {31'd0, irq}, 32'd1);

    // Mode 1 auto-reload, PRESET=3
    do_reset();
    step(1'b1, 2'd1, 32'd3, 1'b0);
    step(1'b1, 2'd0, 32'hB, 1'b0);       // E0
    for (int k = 1; k <= 17; k++) begin
      rd(2'd2);
      check("m1_irq", {31'd0, irq}, {31'd0, (k == 5 || k == 11 || k == 17)});
      if (k == 8 || k == 14) check("m1_reload", rdata, 32'd3);
    end

    // Masked interrupt and ignored writes
    do_reset();
    step(1'b1, 2'd1, 32'd2, 1'b0);
    step(1'b1, 2'd0, 32'h1, 1'b0);       // E0
    for (int k = 1; k <= 4; k++) rd(2'd2);
    check("mask_count", rdata, 32'd0);
    check("mask_irq", {31'd0, irq}, 32'd0);
    step(1'b1, 2'd2, 32'h1234, 1'b0);
    check("count_ro", rdata, 32'd0);
    step(1'b1, 2'd3, 32'hFFFF, 1'b0);
    check("word3", rdata, 32'd0);
    step(1'b1, 2'd0, 32'h8, 1'b0);
    check("unmask_irq", {31'd0, irq}, 32'd1);

    // Disable mid-count, re-enable, PRESET write during CNT
    do_reset();
    step(1'b1, 2'd1, 32'd10, 1'b0);
    step(1'b1, 2'd0, 32'h1, 1'b0);       // E0
    for (int k = 1; k <= 4; k++) rd(2'd2);
    check("dis_run", rdata, 32'd8);
    step(1'b1, 2'd0, 32'h0, 1'b0);       // E5: count 7
    for (int k = 0; k < 3; k++) begin
      rd(2'd2);
      check("dis_freeze", rdata, 32'd7);
    end
    step(1'b1, 2'd0, 32'h1, 1'b0);       // E0'
    rd(2'd2);                             // E1'
    rd(2'd2);                             // E2'
    check("reen_reload", rdata, 32'd10);
    step(1'b1, 2'd1, 32'd3, 1'b0);       // E3'
    rd(2'd2);                             // E4'
    check("preset_in_cnt", rdata, 32'd8);

    // CTRL write landing on the INT cycle wins over the Enable clear
    do_reset();
    step(1'b1, 2'd1, 32'd2, 1'b0);
    step(1'b1, 2'd0, 32'h9, 1'b0);       // E0
    for (int k = 1; k <= 4; k++) rd(2'd2);
    check("race_irq", {31'd0, irq}, 32'd1);
    step(1'b1, 2'd0, 32'h9, 1'b0);       // E5
    check("race_ctrl", rdata, 32'h9);
    rd(2'd2);                             // E6
    check("race_restart_irq", {31'd0, irq}, 32'd0);
    rd(2'd2);                             // E7
    check("race_reload", rdata, 32'd2);

    // PRESET=0 expires on E3
    do_reset();
    step(1'b1, 2'd0, 32'h9, 1'b0);       // E0
    rd(2'd2); rd(2'd2);                   // E1, E2
    check("p0_no_irq", {31'd0, irq}, 32'd0);
    rd(2'd2);                             // E3
    check("p0_irq", {31'd0, irq}, 32'd1);

    // Max preset, reset mid-count
    do_reset();
    step(1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 2'd0, 32'h9, 1'b0);       // E0
    for (int k = 1; k <= 10; k++) rd(2'd2);
    check("max_count", rdata, 32'hFFFF_FFF7);
    step(1'b0, 2'd2, 32'd0, 1'b1);
    check("rst_mid_count", rdata, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0]);
      check("rst_mid_read", rdata, 32'd0);
    end

    // Randomized traffic, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      rw = ($urandom_range(0, 7) == 0);
      ra = 2'($urandom_range(0, 3));
      if (ra == 2'd1 && $urandom_range(0, 9) != 0) rdat = 32'($urandom_range(0, 9));
      else rdat = $urandom;
      step(rw, ra, rdat, rr);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped countdown timer that answers CPU load/store accesses in the two timer windows, 0x7f00–0x7f0b and 0x7f10–0x7f1b. The system bridge instantiates it twice, as Timer0 and Timer1. It is the responder side of the memory-access interface whose legality checks run in the M stage: only word accesses to CTRL and PRESET are written, and only word reads reach it. Its `irq` output feeds the CP0 hardware-interrupt vector.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  30  word address `Addr[31:2]`; only `addr[1:0]` (byte address bits [3:2]) is decoded, and the bridge gates range selection
- `we`  in  1  write enable, already qualified by device select
- `wdata`  in  32  store data
- `rdata`  out  32  read data, combinational from `addr`
- `irq`  out  1  interrupt request, registered flag ANDed with CTRL.IM

## Operation
Registers:
- **CTRL** (word 0): bit0 Enable, bits[2:1] Mode, bit3 IM. Bits[31:4] are not stored and read 0.
- **PRESET** (word 1): 32-bit reload value, read/write.
- **COUNT** (word 2): 32-bit, read-only. Writes are ignored.
- **Word 3**: reads 0, writes ignored.

Register behaviour:
- Write with `we`=1 updates the selected register at the clock edge.
- Mode encodings: 0 = one-shot, 1 = auto-reload. Modes 2 and 3 behave as mode 0.
- An internal flag `irq_r` drives `irq = irq_r & ctrl[3]`.

State machine, states IDLE / LOAD / CNT / INT:
- **IDLE:** if Enable=1, go to LOAD and clear `irq_r`. Otherwise stay in IDLE.
- **LOAD:** set COUNT ← PRESET, go to CNT.
- **CNT:**
  - If Enable=0, go to IDLE; COUNT holds its value.
  - Else if COUNT > 1, COUNT ← COUNT−1.
  - Else COUNT ← 0, `irq_r` ← 1, go to INT.
- **INT:**
  - Mode 0: clear Enable; `irq_r` stays 1; go to IDLE.
  - Mode 1: `irq_r` ← 0; go to IDLE.

Priority and boundary rules:
- A CPU write to CTRL in the same cycle as the INT-state Enable clear wins: the written value is stored.
- A CPU write to PRESET during CNT does not affect the current count. It takes effect at the next LOAD.
- PRESET=0 or 1: LOAD gives COUNT = 0 or 1, and CNT goes to INT on the next edge.
- Clearing Enable while in INT or LOAD still completes that state's actions before IDLE.
- In mode 0, `irq_r` stays high until software re-enables the timer (cleared in IDLE) or reset. Software masks it via IM.

Reset:
- `reset`=1 at an edge sets CTRL=0, PRESET=0, COUNT=0, `irq_r`=0, state=IDLE.
- Reset has priority over any simultaneous write.
- Reset mid-count abandons the count. `irq` is 0 from the next cycle.

## Timing
- Write at edge E0 sets Enable. Then:
  - E1: LOAD.
  - E2: COUNT = P.
  - Each following edge decrements COUNT.
  - E(P+2): COUNT = 0 and `irq_r` = 1, for P ≥ 1.
- Mode 1: `irq` is high for exactly one cycle, after which the timer restarts. Period is P+3 cycles from one IRQ rising edge to the next.
- Mode 0: `irq` stays high from E(P+2) until software clears it; Enable reads 0 from E(P+3).
- `rdata` has zero latency. Reading COUNT returns the value registered at the last edge.
- All outputs reset to 0: `rdata` reads 0 for every address after reset.

## Test plan
1. **Reset values:** assert `reset`, then read words 0–3 → all return 0x0; `irq`=0.
2. **Mode 0 one-shot:**
   - Stimulus: write PRESET=5, then CTRL=0x9 at E0.
   - COUNT reads 5,4,3,2,1 at E2–E6.
   - At E7, COUNT=0 and `irq`=1; `irq` holds.
   - CTRL reads 0x8 after E8.
3. **Mode 1 auto-reload:**
   - Stimulus: PRESET=3, CTRL=0xB.
   - `irq` pulses for one cycle at E5, E11, E17 (period 6).
   - COUNT reloads to 3 each cycle.
4. **Mask and illegal writes:**
   - CTRL=0x1 with PRESET=2: `irq_r` sets at E4 but `irq` stays 0.
   - Writing COUNT=0x1234 leaves COUNT unchanged.
   - Write to word 3, then read word 3 → 0.
5. **Disable and write race:**
   - Clear Enable mid-CNT → COUNT freezes and state returns to IDLE.
   - Re-enable → reload from PRESET.
   - Mode 0 with a CTRL=0x9 write landing on the INT cycle → Enable stays 1, timer restarts.
6. **Edge presets and reset mid-count:**
   - PRESET=0 → `irq` at E3.
   - PRESET=0xFFFFFFFF, assert `reset` after 10 cycles → all registers 0, `irq`=0 on the next cycle.
